operand_entry: RTL
==================

# operand_entry

Parametrised multi-operand decimal entry block for the calculator front end. Debounces the five push buttons with a per-button counter in the `clk` domain; no derived clocks are used. Lets the user edit a signed decimal value digit by digit and commits it into an operand store over a one-cycle write port. Once all operands are committed, it hands the set to the downstream control FSM with a valid/ready handshake.

## Interface
- DIGITS, 4: editable decimal digit positions (1..5).
- OPERANDS, 2: operands collected per set (1..8).
- W, 16: two's-complement data width; must hold ±(10^DIGITS − 1).
- DEB_CYCLES, 1000000: cycles a synchronised button must be stable before it is accepted (10 ms at 100 MHz).
- clk, in, 1: system clock, 100 MHz.
- reset, in, 1: asynchronous, active-high; clock clk.
- btn_c / btn_u / btn_d / btn_l / btn_r, in, 1 each: raw, asynchronous push buttons.
- value, out, W: signed operand currently being edited.
- cursor, out, clog2(DIGITS): active digit; 0 = ones.
- op_idx, out, clog2(OPERANDS): operand currently being edited.
- wr_en, out, 1: one-cycle store write strobe.
- wr_addr, out, clog2(OPERANDS): store address.
- wr_data, out, W: store data.
- set_valid, out, 1: full operand set is in the store.
- set_ready, in, 1: downstream accepts the set.

## Operation
- **Button conditioning.**
  - Each button passes through a 2-flop synchroniser and then a stability counter.
  - The filtered level changes only after DEB_CYCLES consecutive equal samples.
  - A rising edge of the filtered level produces a 1-cycle pulse.
- **Simultaneous pulses.** When several pulses occur in the same cycle, only one is acted on, by priority C > L > R > U > D. The others are dropped.
- **FSM states:** EDIT, COMMIT, HANDOFF. Encoding lives in the package.
- **EDIT state.**
  - L: cursor+1, wraps DIGITS−1 → 0.
  - R: cursor−1, wraps 0 → DIGITS−1.
  - U: value + 10^cursor, clamped to +MAX, where MAX = 10^DIGITS − 1.
  - D: value − 10^cursor, clamped to −MAX.
  - Clamping means the limit is written; the value never wraps.
  - C: go to COMMIT.
- **COMMIT state (exactly 1 cycle).**
  - wr_en=1, wr_addr=op_idx, wr_data=value.
  - If op_idx < OPERANDS−1: op_idx+1, value←0, cursor←0, back to EDIT.
  - Otherwise go to HANDOFF.
- **HANDOFF state.**
  - set_valid=1. All button pulses are ignored and discarded, not queued.
  - On set_valid & set_ready: op_idx←0, value←0, cursor←0, go to EDIT.
- Powers of ten come from a constant lookup indexed by cursor; no runtime multiply.
- Clamp compare is done on a W+1-bit sum to avoid overflow.

## Timing
- **Reset values:**
  - value=0, cursor=0, op_idx=0.
  - wr_en=0, wr_addr=0, wr_data=0, set_valid=0.
  - State EDIT, debounce counters and filtered levels 0.
- **Reset mid-operation:** any state returns to EDIT immediately. No wr_en is emitted during or after assertion. Store contents are not cleared.
- **Press latency:** raw edge → action pulse = 2 sync cycles + DEB_CYCLES. The outputs update on the following clk edge.
- **Glitches:** a glitch shorter than DEB_CYCLES produces no pulse.
- **Long presses:** a held button produces exactly one pulse; no auto-repeat.
- **C pulse:** COMMIT is the next cycle; wr_en is high for exactly that one cycle. The EDIT/HANDOFF transition happens on the cycle after.
- **set_valid:**
  - Rises the cycle after the final COMMIT.
  - Stays high until the handshake edge and falls on the next cycle.
  - set_ready may be high early; the handshake completes in the first HANDOFF cycle.
- All outputs are registered.

## Structure
- **Package `operand_entry_pkg`:** FSM state enum, button index constants and priority order, and a function returning 10^k for k < 5.
- **Sub-module `button_debouncer`:** synchroniser, stability counter and rise-pulse; parameter DEB_CYCLES; instantiated 5×.
- **Top level:** FSM, value datapath and store port only. The store itself (BRAM) is outside this block.

## Test plan
All scenarios use DEB_CYCLES=4.
- **Increment with clamp.** DIGITS=4, cursor=3, value=9500; press U → value=9999 (clamped). Press U again → stays 9999.
- **Cursor and decrement.** From cursor 0, press R → cursor=3. Press D on value 0 at cursor 2 → −100. Press L twice → cursor=1.
- **Bounce rejection.** Toggle btn_u for 3-cycle bursts → no change. Hold 10 cycles → exactly one +10^cursor.
- **Two-operand commit.** Enter 42, press C → wr_en pulse, addr 0, data 42; op_idx=1, value=0. Enter −7, press C → addr 1, data −7; set_valid=1 the next cycle.
- **Handoff handling.**
  - With set_ready=0, press U → value unchanged, no write.
  - Raise set_ready → set_valid drops the next cycle; op_idx=0, state EDIT.
- **Priority and reset.**
  - U and D pulses in the same cycle → only U is applied.
  - Assert reset during COMMIT → wr_en=0 and all outputs equal their reset values.

Source files
------------

// File: rtl/operand_entry_pkg.sv
// Shared types and constants for the operand entry block: FSM states, button
// indices (index order is the action priority) and a small power-of-ten table.
package operand_entry_pkg;

  typedef enum logic [1:0] {
    StEdit    = 2'd0,
    StCommit  = 2'd1,
    StHandoff = 2'd2
  } state_e;

  localparam int unsigned NUM_BTN = 5;

  // Lower index wins when several pulses coincide: C > L > R > U > D.
  localparam int unsigned BTN_C = 0;
  localparam int unsigned BTN_L = 1;
  localparam int unsigned BTN_R = 2;
  localparam int unsigned BTN_U = 3;
  localparam int unsigned BTN_D = 4;

  function automatic int unsigned pow10(input int unsigned k);
    case (k)
      0:       return 1;
      1:       return 10;
      2:       return 100;
      3:       return 1000;
      default: return 10000;
    endcase
  endfunction

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/operand_entry_if.sv
// Operand store write port and set handoff handshake of the operand entry block.
interface operand_entry_if
  import operand_entry_pkg::*;
#(
  parameter int unsigned W        = 16,
  parameter int unsigned OPERANDS = 2
);
  localparam int unsigned AW = idx_width(OPERANDS);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          set_valid;
  logic          set_ready;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output set_valid,
    input  set_ready
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  set_valid,
    output set_ready
  );
endinterface

// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a
// single-cycle pulse on each rising edge of the filtered level.
module button_debouncer #(
  parameter int unsigned DEB_CYCLES = 1000000,
  localparam int unsigned CNTW      = $clog2(DEB_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse
);
  localparam logic [CNTW-1:0] LAST = CNTW'(DEB_CYCLES - 1);

  logic [1:0]      r_sync;
  logic [CNTW-1:0] r_cnt;
  logic            r_level;
  logic            r_pulse;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_pulse <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        // DEB_CYCLES consecutive samples disagreed with the level: accept them.
        r_level <= r_sync[1];
        r_cnt   <= '0;
        r_pulse <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + CNTW'(1);
      end
    end
  end

  assign o_pulse = r_pulse;
endmodule

// File: rtl/operand_entry.sv
// Decimal operand entry: digit-wise editing of a signed value, one-cycle commit
// into an external operand store and valid/ready handoff of the completed set.
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned OPERANDS   = 2,
  parameter int unsigned W          = 16,
  parameter int unsigned DEB_CYCLES = 1000000,
  localparam int unsigned CW        = idx_width(DIGITS),
  localparam int unsigned AW        = idx_width(OPERANDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_btn_c,
  input  logic          i_btn_u,
  input  logic          i_btn_d,
  input  logic          i_btn_l,
  input  logic          i_btn_r,
  output logic [W-1:0]  o_value,
  output logic [CW-1:0] o_cursor,
  output logic [AW-1:0] o_op_idx,
  operand_entry_if.master bus
);
  localparam int unsigned       MAX   = pow10(DIGITS - 1) * 10 - 1;
  localparam logic signed [W:0] MAX_S = (W + 1)'(MAX);
  localparam logic signed [W:0] MIN_S = -MAX_S;

  logic [NUM_BTN-1:0] w_raw;
  logic [NUM_BTN-1:0] w_pulse;

  assign w_raw[BTN_C] = i_btn_c;
  assign w_raw[BTN_L] = i_btn_l;
  assign w_raw[BTN_R] = i_btn_r;
  assign w_raw[BTN_U] = i_btn_u;
  assign w_raw[BTN_D] = i_btn_d;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_deb
    button_debouncer #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .clk     (clk),
      .reset   (reset),
      .i_btn   (w_raw[g]),
      .o_pulse (w_pulse[g])
    );
  end

  state_e        r_state, w_state_next;
  logic [W-1:0]  r_value, w_value_next;
  logic [CW-1:0] r_cursor, w_cursor_next;
  logic [AW-1:0] r_op_idx, w_op_next;
  logic          r_wr_en, w_wr_en_next;
  logic [AW-1:0] r_wr_addr, w_wr_addr_next;
  logic [W-1:0]  r_wr_data, w_wr_data_next;
  logic          r_set_valid, w_set_valid_next;

  // Sign-extended by one bit so the clamp compare cannot overflow.
  logic signed [W:0] w_ext, w_step, w_up, w_dn;

  assign w_ext  = $signed({r_value[W-1], r_value});
  assign w_step = (W + 1)'(pow10(32'(r_cursor)));
  assign w_up   = w_ext + w_step;
  assign w_dn   = w_ext - w_step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StEdit;
      r_value     <= '0;
      r_cursor    <= '0;
      r_op_idx    <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_set_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_value     <= w_value_next;
      r_cursor    <= w_cursor_next;
      r_op_idx    <= w_op_next;
      r_wr_en     <= w_wr_en_next;
      r_wr_addr   <= w_wr_addr_next;
      r_wr_data   <= w_wr_data_next;
      r_set_valid <= w_set_valid_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_value_next     = r_value;
    w_cursor_next    = r_cursor;
    w_op_next        = r_op_idx;
    w_wr_en_next     = 1'b0;
    w_wr_addr_next   = r_wr_addr;
    w_wr_data_next   = r_wr_data;
    w_set_valid_next = 1'b0;
    unique case (r_state)
      StEdit: begin
        if (w_pulse[BTN_C]) begin
          // Write strobe is registered so it is high during the COMMIT cycle.
          w_state_next   = StCommit;
          w_wr_en_next   = 1'b1;
          w_wr_addr_next = r_op_idx;
          w_wr_data_next = r_value;
        end else if (w_pulse[BTN_L]) begin
          w_cursor_next = (r_cursor == CW'(DIGITS - 1)) ? '0 : r_cursor + CW'(1);
        end else if (w_pulse[BTN_R]) begin
          w_cursor_next = (r_cursor == '0) ? CW'(DIGITS - 1) : r_cursor - CW'(1);
        end else if (w_pulse[BTN_U]) begin
          w_value_next = (w_up > MAX_S) ? MAX_S[W-1:0] : w_up[W-1:0];
        end else if (w_pulse[BTN_D]) begin
          w_value_next = (w_dn < MIN_S) ? MIN_S[W-1:0] : w_dn[W-1:0];
        end
      end
      StCommit: begin
        if (r_op_idx == AW'(OPERANDS - 1)) begin
          w_state_next     = StHandoff;
          w_set_valid_next = 1'b1;
        end else begin
          w_state_next  = StEdit;
          w_op_next     = r_op_idx + AW'(1);
          w_value_next  = '0;
          w_cursor_next = '0;
        end
      end
      StHandoff: begin
        if (r_set_valid && bus.set_ready) begin
          w_state_next  = StEdit;
          w_op_next     = '0;
          w_value_next  = '0;
          w_cursor_next = '0;
        end else begin
          w_set_valid_next = 1'b1;
        end
      end
      default: w_state_next = StEdit;
    endcase
  end

  assign o_value       = r_value;
  assign o_cursor      = r_cursor;
  assign o_op_idx      = r_op_idx;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.set_valid = r_set_valid;
endmodule
